envelope_follower: RTL and testbench
====================================

# envelope_follower

Per-band amplitude envelope detector. It sits directly downstream of each analysis band-pass filter in the vocoder. It consumes the filter's signed sample stream at audio rate and produces a smoothed unsigned envelope per sample. The carrier-side gain stage uses that envelope to modulate the matching synthesis band. Processing is a short multi-cycle FSM with a one-pole attack/release smoother.

## Interface
- WIDTH, 24: sample and envelope width in bits.
- FRAC, 8: extra fractional bits in the internal envelope accumulator.
- ATTACK_SHIFT, 2: attack coefficient is 2^-ATTACK_SHIFT.
- RELEASE_SHIFT, 6: release coefficient is 2^-RELEASE_SHIFT.
- HOLD_SAMPLES, 4: peak-hold length in input samples; used only when ENV_PEAK_HOLD_EN is defined.

Ports:
- clk_in, input, 1: system clock. One clock; reset is asynchronous and active-low.
- rstn_in, input, 1: asynchronous active-low reset.
- sample_in, input, WIDTH (signed): band-filter output sample.
- sample_valid_in, input, 1: one-cycle strobe, sample_in valid.
- sample_ready_out, output, 1: high when a new sample will be accepted.
- env_out, output, WIDTH (unsigned): current envelope, range 0..2^(WIDTH-1)-1.
- env_valid_out, output, 1: one-cycle strobe, env_out updated.
- overrun_out, output, 1: sticky flag, a sample arrived while busy.

## Operation
- FSM states and transitions:
  - IDLE: sample_ready_out=1. On sample_valid_in, latch sample_in and go to RECT.
  - RECT: compute r = |x|. The value -2^(WIDTH-1) saturates to 2^(WIDTH-1)-1. Go to UPDATE.
  - UPDATE: form t = r << FRAC, then apply the first matching rule and go to EMIT.
    - If t > acc: acc += (t-acc) >> ATTACK_SHIFT.
    - Else, if the hold counter is nonzero (macro builds only), acc is unchanged.
    - Otherwise: acc -= (acc-t) >> RELEASE_SHIFT.
  - EMIT: env_out = acc >> FRAC, pulse env_valid_out, go to IDLE.
- Accumulator:
  - acc is unsigned, WIDTH-1+FRAC bits. It is never negative and never exceeds (2^(WIDTH-1)-1) << FRAC.
  - Shifts are logical and truncate toward zero.
  - When t == acc, acc is unchanged.
- Busy handling:
  - sample_valid_in outside IDLE is dropped and sets overrun_out.
  - overrun_out clears only on reset.
  - A valid arriving in the same cycle the FSM returns to IDLE (the EMIT cycle) counts as overrun.
- Reset:
  - Asserting rstn_in at any time, including mid-FSM, immediately forces the FSM to IDLE and clears acc and the hold counter.
  - Outputs during reset: env_out=0, env_valid_out=0, overrun_out=0, sample_ready_out=1.
  - An in-flight sample is discarded with no env_valid_out.

## Timing
- Sample accepted at the clock edge at the end of cycle N (valid high in IDLE). Then RECT in N+1, UPDATE in N+2, EMIT in N+3.
- env_valid_out is high for exactly cycle N+3, and env_out holds the new value from N+3 until the next EMIT.
- Latency is 3 cycles from the accepting edge to the strobe. Minimum spacing between accepted samples is 4 cycles.
- sample_ready_out is low in cycles N+1..N+3 and high again in N+4.
- Output is registered; no combinational path from sample_in to any output.

## Configuration
- ENV_PEAK_HOLD_EN defined:
  - A hold counter loads HOLD_SAMPLES whenever the attack branch is taken.
  - Otherwise it decrements once per accepted sample, saturating at 0.
  - Release is suppressed while the counter is nonzero at the start of UPDATE.
- ENV_PEAK_HOLD_EN undefined: no counter is built, and release applies on every sample where t < acc.

## Test plan
- Reset: hold rstn_in low for 5 cycles with random sample_valid_in → env_out=0, env_valid_out=0, overrun_out=0, sample_ready_out=1 throughout.
- Attack step (WIDTH=24, FRAC=8, ATTACK_SHIFT=2): feed 1048576 twice, 4 cycles apart → env_out 262144, then 458752, each strobed 3 cycles after acceptance.
- Negative full scale: feed -8388608 from reset → env_out=2097151; the rectified value saturates and there is no wrap.
- Release (macro off, RELEASE_SHIFT=6): after acc=1048576<<8, feed 0 → env_out=1032192, then 1016064.
- Overrun: valids in cycles 0 and 1 → one env_valid_out in cycle 3, second sample ignored, overrun_out=1 from cycle 2 until reset. Also assert reset in cycle 2 → no strobe and overrun_out=0.
- Peak hold (macro on, HOLD_SAMPLES=4): feed 1048576, then zeros → env_out=262144 for the next 4 strobes, then decays to 258048 on the 5th zero.

Source files
------------

// File: rtl/envelope_follower.sv
// Per-band envelope detector: rectify, then one-pole attack/release smoothing, 3 cycles from acceptance to the env_valid_out strobe.
// Accepts one sample every 4 cycles; samples arriving while busy are dropped and set sticky overrun_out. ENV_PEAK_HOLD_EN adds peak hold.
module envelope_follower #(
  parameter int WIDTH         = 24,
  parameter int FRAC          = 8,
  parameter int ATTACK_SHIFT  = 2,
  parameter int RELEASE_SHIFT = 6,
  parameter int HOLD_SAMPLES  = 4
) (
  input  logic                    clk_in,
  input  logic                    rstn_in,
  input  logic signed [WIDTH-1:0] sample_in,
  input  logic                    sample_valid_in,
  output logic                    sample_ready_out,
  output logic [WIDTH-1:0]        env_out,
  output logic                    env_valid_out,
  output logic                    overrun_out
);

  localparam int AW = WIDTH - 1 + FRAC;
  localparam logic [WIDTH-1:0] X_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-2:0] R_MAX = {(WIDTH-1){1'b1}};

  typedef enum logic [1:0] {IDLE, RECT, UPDATE, EMIT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] x_neg;
  logic [WIDTH-2:0] r_q, r_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW-1:0]    t_val, up_diff, dn_diff;
  logic             attack;
  logic             hold_active;
  logic             overrun_q;

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_valid_in) state_d = RECT;
      RECT:    state_d = UPDATE;
      UPDATE:  state_d = EMIT;
      EMIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sample_ready_out = (state_q == IDLE);
    env_valid_out    = (state_q == EMIT);
    env_out          = {1'b0, acc_q[AW-1:FRAC]};
    overrun_out      = overrun_q;
  end

  // The most negative input has no positive twin; clamp it to full scale.
  always_comb begin
    x_neg = -x_q;
    if (x_q == X_MIN)   r_d = R_MAX;
    else if (x_q[WIDTH-1]) r_d = x_neg[WIDTH-2:0];
    else                r_d = x_q[WIDTH-2:0];
  end

  always_comb begin
    t_val   = {r_q, {FRAC{1'b0}}};
    attack  = (t_val > acc_q);
    up_diff = t_val - acc_q;
    dn_diff = acc_q - t_val;
    acc_d   = acc_q;
    if (attack)            acc_d = acc_q + (up_diff >> ATTACK_SHIFT);
    else if (!hold_active) acc_d = acc_q - (dn_diff >> RELEASE_SHIFT);
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      x_q       <= '0;
      r_q       <= '0;
      acc_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (sample_valid_in && state_q != IDLE) overrun_q <= 1'b1;
      if (sample_valid_in && state_q == IDLE) x_q <= sample_in;
      if (state_q == RECT)   r_q   <= r_d;
      if (state_q == UPDATE) acc_q <= acc_d;
    end
  end

`ifdef ENV_PEAK_HOLD_EN
  localparam int HW = $clog2(HOLD_SAMPLES + 1);
  logic [HW-1:0] hold_q;

  assign hold_active = (hold_q != '0);

  // Reloaded on every attack, otherwise counts down once per processed sample.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      hold_q <= '0;
    end else if (state_q == UPDATE) begin
      if (attack)           hold_q <= HW'(HOLD_SAMPLES);
      else if (hold_active) hold_q <= hold_q - HW'(1);
    end
  end
`else
  assign hold_active = 1'b0;
`endif

endmodule

// File: tb/tb_envelope_follower.sv
// Directed bench for envelope_follower with hand-computed envelopes; covers ENV_PEAK_HOLD_EN in either build.
module tb_envelope_follower;

  logic        clk_in;
  logic        rstn_in;
  logic [23:0] sample_in;
  logic        sample_valid_in;
  logic        sample_ready_out;
  logic [23:0] env_out;
  logic        env_valid_out;
  logic        overrun_out;

  int errors = 0;
  int checks = 0;

  envelope_follower #(
    .WIDTH(24), .FRAC(8), .ATTACK_SHIFT(2), .RELEASE_SHIFT(6), .HOLD_SAMPLES(4)
  ) dut (
    .clk_in          (clk_in),
    .rstn_in         (rstn_in),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .sample_ready_out(sample_ready_out),
    .env_out         (env_out),
    .env_valid_out   (env_valid_out),
    .overrun_out     (overrun_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rstn_in = 1'b0;
    sample_valid_in = 1'b0;
    step();
    step();
    rstn_in = 1'b1;
    step();
  endtask

  // Starts in an IDLE cycle, ends in cycle N+4 (IDLE again).
  task automatic send(input string tag, input logic [23:0] val, input logic [23:0] exp_env);
    check({tag, "_ready_n"}, sample_ready_out, 1);
    sample_in = val;
    sample_valid_in = 1'b1;
    step();
    sample_valid_in = 1'b0;
    check({tag, "_ready_n1"}, sample_ready_out, 0);
    check({tag, "_vld_n1"}, env_valid_out, 0);
    step();
    check({tag, "_vld_n2"}, env_valid_out, 0);
    step();
    check({tag, "_vld_n3"}, env_valid_out, 1);
    check({tag, "_ready_n3"}, sample_ready_out, 0);
    check({tag, "_env_n3"}, env_out, exp_env);
    step();
    check({tag, "_vld_n4"}, env_valid_out, 0);
    check({tag, "_ready_n4"}, sample_ready_out, 1);
    check({tag, "_env_n4"}, env_out, exp_env);
  endtask

  initial begin
    rstn_in = 1'b0;
    sample_valid_in = 1'b0;
    sample_in = '0;

    for (int i = 0; i < 5; i++) begin
      sample_valid_in = 1'($urandom_range(0, 1));
      sample_in = 24'($urandom);
      step();
      check("rst_env", env_out, 0);
      check("rst_vld", env_valid_out, 0);
      check("rst_ovr", overrun_out, 0);
      check("rst_rdy", sample_ready_out, 1);
    end
    sample_valid_in = 1'b0;
    rstn_in = 1'b1;
    step();

    send("atk1", 24'd1048576, 24'd262144);
    send("atk2", 24'd1048576, 24'd458752);
    check("atk_ovr", overrun_out, 0);

    do_reset();
    send("negfs", 24'h800000, 24'd2097151);

`ifndef ENV_PEAK_HOLD_EN
    do_reset();
    send("rel_load", 24'd4194304, 24'd1048576);
    send("rel1", 24'd0, 24'd1032192);
    send("rel2", 24'd0, 24'd1016064);
`else
    do_reset();
    send("hold_load", 24'd1048576, 24'd262144);
    for (int i = 0; i < 4; i++) send("hold_keep", 24'd0, 24'd262144);
    send("hold_decay", 24'd0, 24'd258048);
`endif

    // Back-to-back valids: second one is dropped and flagged.
    do_reset();
    sample_in = 24'd1048576;
    sample_valid_in = 1'b1;
    step();
    sample_in = 24'd4194304;
    check("ovr_c1", overrun_out, 0);
    step();
    sample_valid_in = 1'b0;
    check("ovr_c2", overrun_out, 1);
    check("ovr_c2_vld", env_valid_out, 0);
    step();
    check("ovr_c3_vld", env_valid_out, 1);
    check("ovr_c3_env", env_out, 262144);
    step();
    check("ovr_c4_vld", env_valid_out, 0);
    check("ovr_c4_rdy", sample_ready_out, 1);
    send("ovr_after", 24'd1048576, 24'd458752);
    check("ovr_sticky", overrun_out, 1);

    // Valid during the EMIT cycle counts as overrun and is not processed.
    do_reset();
    sample_in = 24'd1048576;
    sample_valid_in = 1'b1;
    step();
    sample_valid_in = 1'b0;
    step();
    step();
    check("emit_vld", env_valid_out, 1);
    check("emit_ovr_pre", overrun_out, 0);
    sample_valid_in = 1'b1;
    step();
    sample_valid_in = 1'b0;
    check("emit_ovr", overrun_out, 1);
    check("emit_rdy", sample_ready_out, 1);
    step();
    check("emit_no_rect", sample_ready_out, 1);

    // Reset mid-flight discards the sample and clears overrun.
    do_reset();
    sample_in = 24'd1048576;
    sample_valid_in = 1'b1;
    step();
    step();
    sample_valid_in = 1'b0;
    check("rstmid_ovr_pre", overrun_out, 1);
    rstn_in = 1'b0;
    #1;
    check("rstmid_ovr", overrun_out, 0);
    check("rstmid_rdy", sample_ready_out, 1);
    step();
    check("rstmid_vld", env_valid_out, 0);
    rstn_in = 1'b1;
    step();
    check("rstmid_vld2", env_valid_out, 0);
    check("rstmid_env", env_out, 0);
    check("rstmid_ovr2", overrun_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
